// File: rtl/usbuart_in_pkt_sched.sv
// Purpose : packs the usbuart TX byte stream into USB bulk IN packets, answers IN tokens with DATA/NAK, keeps packet until ACK, tracks DATA0/1.
// Latency : first packet byte is presented the cycle after an accepted IN token; NAK pulses the cycle after a refused token.
// Backpr. : FIFO pops only while filling and the buffer has room; packet bytes hold stable on in_valid_o until in_ready_i. Optional ZLP: USBUART_IN_ZLP_EN.
module usbuart_in_pkt_sched #(
    parameter int MaxPktSize = 64,
    parameter int TimeoutW   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                fifo_rvalid_i,
    input  logic [7:0]          fifo_rdata_i,
    output logic                fifo_rready_o,
    input  logic [TimeoutW-1:0] timeout_i,
    input  logic                in_token_i,
    input  logic                in_ack_i,
    output logic                in_nak_o,
    output logic                in_valid_o,
    output logic [7:0]          in_data_o,
    output logic                in_last_o,
    output logic                in_empty_o,
    input  logic                in_ready_i,
    output logic                data_pid_o,
    output logic                busy_o,
    output logic [6:0]          pkt_len_o
);

    localparam int AddrW = $clog2(MaxPktSize);
    localparam int CntW  = AddrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(MaxPktSize);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       count_q;
    logic [CntW-1:0]       idx_q;
    logic [TimeoutW-1:0]   timer_q;
    logic                  toggle_q;
    logic                  nak_q;
    logic                  zlp_pending;
    logic [7:0]            pkt_buf [MaxPktSize];

    logic full;
    logic pop;
    logic timed_out;
    logic pkt_ready;
    logic is_last;
    logic tok_accept;
    logic nak_set;
    logic byte_acc;
    logic ack_take;
    logic retx;

    assign full          = (count_q == FullCnt);
    assign fifo_rready_o = fifo_rvalid_i & (state_q == ST_FILL) & ~full;
    assign pop           = fifo_rready_o;
    assign timed_out     = (timeout_i != '0) && (timer_q >= timeout_i);
    assign pkt_ready     = full | (timed_out & ((count_q != '0) | zlp_pending));
    // An empty packet is a single-beat ZLP; otherwise the last beat is count-1.
    assign is_last       = (count_q == '0) | (idx_q == (count_q - CntOne));

    assign in_nak_o   = nak_q;
    assign data_pid_o = toggle_q;
    assign busy_o     = (state_q != ST_FILL);
    assign pkt_len_o  = 7'(count_q);
    assign in_data_o  = (state_q == ST_SEND && count_q != '0) ? pkt_buf[idx_q[AddrW-1:0]] : 8'h00;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the packet-side handshake outputs.
    always_comb begin
        state_d    = state_q;
        in_valid_o = 1'b0;
        in_last_o  = 1'b0;
        in_empty_o = 1'b0;
        tok_accept = 1'b0;
        nak_set    = 1'b0;
        byte_acc   = 1'b0;
        ack_take   = 1'b0;
        retx       = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (in_token_i) begin
                    if (pkt_ready) begin
                        tok_accept = 1'b1;
                        state_d    = ST_SEND;
                    end else begin
                        nak_set = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                in_valid_o = 1'b1;
                in_last_o  = is_last;
`ifdef USBUART_IN_ZLP_EN
                in_empty_o = (count_q == '0);
`endif
                // Tokens here are ignored; only the transmitter handshake matters.
                if (in_ready_i) begin
                    byte_acc = 1'b1;
                    if (is_last) begin
                        state_d = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                // ACK beats a coincident token: the packet got through.
                if (in_ack_i) begin
                    ack_take = 1'b1;
                    state_d  = ST_FILL;
                end else if (in_token_i) begin
                    retx    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
        if (clear_i) begin
            state_d = ST_FILL;
        end
    end

    // Packet buffer write; contents are only read below count, so no reset.
    always_ff @(posedge clk_i) begin
        if (pop) begin
            pkt_buf[count_q[AddrW-1:0]] <= fifo_rdata_i;
        end
    end

    // Byte count: grows on each pop, drops to zero once the host ACKs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear_i || ack_take) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + CntOne;
        end
    end

    // Read index: rewinds on every (re)transmit start, steps on each accepted beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else if (clear_i || tok_accept || retx) begin
            idx_q <= '0;
        end else if (byte_acc && !is_last) begin
            idx_q <= idx_q + CntOne;
        end
    end

    // Flush timer: counts idle fill cycles since the last pop, saturating.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q <= '0;
        end else if (clear_i || ack_take) begin
            timer_q <= '0;
        end else if (state_q == ST_FILL) begin
            if (pop) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + TimeoutW'(1);
            end
        end
    end

    // DATA0/DATA1 toggle flips only on a successful ACK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            toggle_q <= 1'b0;
        end else if (clear_i) begin
            toggle_q <= 1'b0;
        end else if (ack_take) begin
            toggle_q <= ~toggle_q;
        end
    end

    // NAK answer is a registered one-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nak_q <= 1'b0;
        end else if (clear_i) begin
            nak_q <= 1'b0;
        end else begin
            nak_q <= nak_set;
        end
    end

`ifdef USBUART_IN_ZLP_EN
    logic zlp_pending_q;
    // A full-size packet must be followed by a short one; remember that on ACK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zlp_pending_q <= 1'b0;
        end else if (clear_i) begin
            zlp_pending_q <= 1'b0;
        end else if (ack_take) begin
            zlp_pending_q <= full;
        end
    end
    assign zlp_pending = zlp_pending_q;
`else
    assign zlp_pending = 1'b0;
`endif

endmodule

// File: tb/tb_usbuart_in_pkt_sched.sv
// Purpose : directed bench for usbuart_in_pkt_sched with a queue-modelled TX FIFO.
// Latency : inputs change 1 ns after the rising edge, outputs are checked 2 ns after it.
// Backpr. : the transmitter side is driven by in_ready_i, including a 5-cycle stall.
module tb_usbuart_in_pkt_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        fifo_rvalid_i;
    logic [7:0]  fifo_rdata_i;
    logic        fifo_rready_o;
    logic [15:0] timeout_i;
    logic        in_token_i;
    logic        in_ack_i;
    logic        in_nak_o;
    logic        in_valid_o;
    logic [7:0]  in_data_o;
    logic        in_last_o;
    logic        in_empty_o;
    logic        in_ready_i;
    logic        data_pid_o;
    logic        busy_o;
    logic [6:0]  pkt_len_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] fq[$];

    usbuart_in_pkt_sched #(.MaxPktSize(64), .TimeoutW(16)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .fifo_rvalid_i (fifo_rvalid_i),
        .fifo_rdata_i  (fifo_rdata_i),
        .fifo_rready_o (fifo_rready_o),
        .timeout_i     (timeout_i),
        .in_token_i    (in_token_i),
        .in_ack_i      (in_ack_i),
        .in_nak_o      (in_nak_o),
        .in_valid_o    (in_valid_o),
        .in_data_o     (in_data_o),
        .in_last_o     (in_last_o),
        .in_empty_o    (in_empty_o),
        .in_ready_i    (in_ready_i),
        .data_pid_o    (data_pid_o),
        .busy_o        (busy_o),
        .pkt_len_o     (pkt_len_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; the FIFO model pops if the DUT asked for a byte at that edge.
    task automatic tick();
        logic popped;
        @(negedge clk_i);
        popped = fifo_rready_o;
        @(posedge clk_i);
        #1;
        if (popped) void'(fq.pop_front());
        fifo_rvalid_i = (fq.size() != 0);
        fifo_rdata_i  = (fq.size() != 0) ? fq[0] : 8'h00;
        #1;
    endtask

    task automatic push(input int n, input logic [7:0] start);
        for (int i = 0; i < n; i++) fq.push_back(8'(int'(start) + i));
        fifo_rvalid_i = 1'b1;
        fifo_rdata_i  = fq[0];
        #1;
    endtask

    // Receive n consecutive bytes start, start+1, ... ; optional 5-cycle stall before byte stall_at.
    task automatic recv(input int n, input logic [7:0] start, input logic pid, input int stall_at);
        logic [7:0] b;
        in_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            b = 8'(int'(start) + i);
            if (i == stall_at) begin
                in_ready_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    in_token_i = (s == 2);
                    tick();
                    in_token_i = 1'b0;
                    chk("stall_vld", 32'(in_valid_o), 32'd1);
                    chk("stall_dat", 32'(in_data_o), 32'(b));
                end
                in_ready_i = 1'b1;
            end
            chk("pkt_vld", 32'(in_valid_o), 32'd1);
            chk("pkt_dat", 32'(in_data_o), 32'(b));
            chk("pkt_last", 32'(in_last_o), (i == n - 1) ? 32'd1 : 32'd0);
            chk("pkt_empty", 32'(in_empty_o), 32'd0);
            chk("pkt_pid", 32'(data_pid_o), 32'(pid));
            tick();
        end
        in_ready_i = 1'b0;
        chk("post_vld", 32'(in_valid_o), 32'd0);
        chk("post_busy", 32'(busy_o), 32'd1);
    endtask

    task automatic token();
        in_token_i = 1'b1;
        tick();
        in_token_i = 1'b0;
    endtask

    task automatic ack();
        in_ack_i = 1'b1;
        tick();
        in_ack_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; fifo_rvalid_i = 1'b0; fifo_rdata_i = 8'h00;
        timeout_i = 16'd0; in_token_i = 1'b0; in_ack_i = 1'b0; in_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_rready", 32'(fifo_rready_o), 32'd0);
        chk("rst_nak", 32'(in_nak_o), 32'd0);
        chk("rst_vld", 32'(in_valid_o), 32'd0);
        chk("rst_last", 32'(in_last_o), 32'd0);
        chk("rst_empty", 32'(in_empty_o), 32'd0);
        chk("rst_dat", 32'(in_data_o), 32'd0);
        chk("rst_pid", 32'(data_pid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_len", 32'(pkt_len_o), 32'd0);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i);
        #2;

        // Short packet flushed by timeout; NAK before it expires.
        timeout_i = 16'd10;
        push(3, 8'h41);
        chk("t1_rready", 32'(fifo_rready_o), 32'd1);
        repeat (3) tick();
        chk("t1_len3", 32'(pkt_len_o), 32'd3);
        chk("t1_rready_off", 32'(fifo_rready_o), 32'd0);
        repeat (5) tick();                       // timer = 5
        token();
        chk("t1_nak_t5", 32'(in_nak_o), 32'd1);
        chk("t1_busy_nak", 32'(busy_o), 32'd0);
        tick();                                  // timer = 7
        chk("t1_nak_pulse", 32'(in_nak_o), 32'd0);
        repeat (2) tick();                       // timer = 9
        token();                                 // timer 9 < 10: refused
        chk("t1_nak_t9", 32'(in_nak_o), 32'd1);
        token();                                 // timer 10: accepted
        chk("t1_nak_t10", 32'(in_nak_o), 32'd0);
        chk("t1_busy", 32'(busy_o), 32'd1);
        recv(3, 8'h41, 1'b0, -1);

        // No ACK: a new token replays the same packet with the same PID.
        token();
        recv(3, 8'h41, 1'b0, -1);
        // ACK together with a token: ACK wins.
        in_token_i = 1'b1;
        ack();
        in_token_i = 1'b0;
        chk("t3_len", 32'(pkt_len_o), 32'd0);
        chk("t3_busy", 32'(busy_o), 32'd0);
        chk("t3_vld", 32'(in_valid_o), 32'd0);
        chk("t3_pid", 32'(data_pid_o), 32'd1);
        tick();
        chk("t3_nonak", 32'(in_nak_o), 32'd0);
        ack();                                   // stray ACK in FILL ignored
        chk("t3_stray_ack", 32'(data_pid_o), 32'd1);

        // 70 bytes, timeout off: buffer caps at 64, stall mid-packet.
        timeout_i = 16'd0;
        push(70, 8'h80);
        repeat (63) tick();
        chk("t2_len63", 32'(pkt_len_o), 32'd63);
        chk("t2_rready63", 32'(fifo_rready_o), 32'd1);
        tick();
        chk("t2_len64", 32'(pkt_len_o), 32'd64);
        chk("t2_rready64", 32'(fifo_rready_o), 32'd0);
        repeat (3) tick();
        chk("t2_len_hold", 32'(pkt_len_o), 32'd64);
        token();
        recv(64, 8'h80, 1'b1, 10);
        ack();
        chk("t2_ack_pid", 32'(data_pid_o), 32'd0);
        chk("t2_ack_len", 32'(pkt_len_o), 32'd0);
        repeat (6) tick();
        chk("t2_len6", 32'(pkt_len_o), 32'd6);
        chk("t2_rready6", 32'(fifo_rready_o), 32'd0);
        repeat (3) tick();
        token();
        chk("t2_nak_noto", 32'(in_nak_o), 32'd1);
        timeout_i = 16'd1;
        token();
        chk("t2_busy_to", 32'(busy_o), 32'd1);
        recv(6, 8'hC0, 1'b0, -1);
        ack();
        chk("t2_pid2", 32'(data_pid_o), 32'd1);

        // Clear during SEND.
        push(2, 8'h10);
        repeat (3) tick();                       // timer = 1
        token();
        chk("t6_vld", 32'(in_valid_o), 32'd1);
        chk("t6_dat", 32'(in_data_o), 32'h10);
        chk("t6_pid", 32'(data_pid_o), 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t6_clr_busy", 32'(busy_o), 32'd0);
        chk("t6_clr_vld", 32'(in_valid_o), 32'd0);
        chk("t6_clr_len", 32'(pkt_len_o), 32'd0);
        chk("t6_clr_pid", 32'(data_pid_o), 32'd0);
        tick();
        token();
        chk("t6_empty_nak", 32'(in_nak_o), 32'd1);

        // Async reset while waiting for ACK.
        push(2, 8'h20);
        repeat (3) tick();
        token();
        recv(2, 8'h20, 1'b0, -1);
        rst_ni = 1'b0;
        #1;
        chk("t7_rst_busy", 32'(busy_o), 32'd0);
        chk("t7_rst_len", 32'(pkt_len_o), 32'd0);
        chk("t7_rst_vld", 32'(in_valid_o), 32'd0);
        chk("t7_rst_pid", 32'(data_pid_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // Full packet then empty FIFO: ZLP only when the feature is built in.
        timeout_i = 16'd0;
        push(64, 8'h00);
        repeat (64) tick();
        token();
        recv(64, 8'h00, 1'b0, -1);
        ack();
        chk("t4_pid", 32'(data_pid_o), 32'd1);
        timeout_i = 16'd4;
        repeat (3) tick();                       // timer = 3
        token();
        chk("t4_nak_t3", 32'(in_nak_o), 32'd1);
        token();                                 // timer = 4
`ifdef USBUART_IN_ZLP_EN
        chk("t4_zlp_busy", 32'(busy_o), 32'd1);
        chk("t4_zlp_vld", 32'(in_valid_o), 32'd1);
        chk("t4_zlp_last", 32'(in_last_o), 32'd1);
        chk("t4_zlp_empty", 32'(in_empty_o), 32'd1);
        chk("t4_zlp_pid", 32'(data_pid_o), 32'd1);
        in_ready_i = 1'b1;
        tick();
        in_ready_i = 1'b0;
        chk("t4_zlp_done", 32'(in_valid_o), 32'd0);
        ack();
        chk("t4_zlp_ackpid", 32'(data_pid_o), 32'd0);
        repeat (5) tick();
        token();
        chk("t4_zlp_nak", 32'(in_nak_o), 32'd1);
`else
        chk("t4_nozlp_nak", 32'(in_nak_o), 32'd1);
        chk("t4_nozlp_busy", 32'(busy_o), 32'd0);
        chk("t4_nozlp_vld", 32'(in_valid_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usbuart_in_pkt_sched.md
Name: usbuart_in_pkt_sched

Overview:
Sequences the usbuart TX byte stream into USB bulk IN packets. It pulls bytes from the TX FIFO into a local packet buffer and decides when a packet is ready: buffer full, or flush timeout expired. It answers host IN tokens with DATA or NAK, holds the packet for retransmit until the host ACKs, and tracks the DATA0/DATA1 toggle. It sits between the usbuart TX FIFO and the USB packet transmitter inside the usbuart core.

Parameters:
MaxPktSize, 64, maximum bytes per IN packet (power of 2, 8..64)
TimeoutW, 16, width of the flush-timeout counter and of timeout_i

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
clear_i  input  1  synchronous flush: empty buffer, reset toggle, go to FILL
fifo_rvalid_i  input  1  TX FIFO has a byte
fifo_rdata_i  input  8  TX FIFO byte
fifo_rready_o  output  1  pop TX FIFO
timeout_i  input  TimeoutW  flush timeout in clk_i cycles; 0 = flush disabled (only full packets sent)
in_token_i  input  1  one-cycle pulse: host IN token for this endpoint
in_ack_i  input  1  one-cycle pulse: host ACKed the last DATA packet
in_nak_o  output  1  one-cycle pulse: respond NAK to the token
in_valid_o  output  1  packet byte valid to transmitter
in_data_o  output  8  packet byte
in_last_o  output  1  final byte (or ZLP marker) of the packet
in_empty_o  output  1  with in_valid_o/in_last_o: zero-length packet, in_data_o ignored
in_ready_i  input  1  transmitter accepts byte
data_pid_o  output  1  0 = DATA0, 1 = DATA1 for the packet being sent
busy_o  output  1  state is not FILL
pkt_len_o  output  7  bytes held in buffer

Behaviour:
- Reset / clear_i: state FILL, count=0, timer=0, toggle=0, zlp_pending=0. All outputs 0. clear_i takes priority over every other input.
- fifo_rready_o = fifo_rvalid_i & state==FILL & count<MaxPktSize. On a pop, the byte is written to buf[count], count+1 next cycle, timer cleared.
- Timer: increments in FILL when no pop occurs and saturates at all-ones. It is cleared on a pop, and cleared on ACK.
- pkt_ready = (count==MaxPktSize) | (timeout_i!=0 & timer>=timeout_i & (count!=0 | zlp_pending)).
- FILL:
  - On in_token_i with pkt_ready: go to SEND with idx=0. A pop in the same cycle still completes and is included in the packet.
  - On in_token_i with !pkt_ready: in_nak_o=1 in the next cycle; state stays FILL.
- SEND:
  - in_valid_o=1, in_data_o=buf[idx], data_pid_o=toggle.
  - in_last_o=1 when idx==count-1.
  - If count==0 (ZLP): in_valid_o=in_last_o=in_empty_o=1.
  - Each in_ready_i&in_valid_o advances idx. Accepting the last byte moves to WAIT_ACK. No FIFO pops occur in SEND or WAIT_ACK.
  - in_valid_o stays 1 with stable data until accepted; no gaps are required.
- WAIT_ACK:
  - On in_ack_i: toggle flips; zlp_pending = (count==MaxPktSize); count=0; timer=0; go to FILL.
  - On in_token_i, treated as a lost packet: return to SEND with idx=0 and the same data and same toggle.
  - in_ack_i and in_token_i in the same cycle: ACK wins.
  - in_ack_i outside WAIT_ACK is ignored.
- A packet with 0<count<MaxPktSize, once ACKed, leaves zlp_pending=0.
- in_token_i during SEND is ignored.
- Latency: first byte is valid the cycle after the accepted token.

Optional Feature:
USBUART_IN_ZLP_EN:
- Defined: after an ACKed full-size packet, zlp_pending=1. The next ready packet with count==0 is sent as a ZLP (in_empty_o=1) once the flush timeout expires.
- Not defined: zlp_pending is held 0 and in_empty_o is tied 0. Only non-empty packets are ever sent.

Test Plan:
- timeout_i=10, push 3 bytes 0x41,0x42,0x43, token at timer=5 → in_nak_o pulse. Token after timer≥10 → 3 bytes sent, in_last_o on 0x43, data_pid_o=0. in_ack_i → pkt_len_o=0, next packet data_pid_o=1.
- Push 70 bytes, timeout_i=0 → fifo_rready_o drops at count=64. Token → 64 bytes sent, last on byte 63. ACK → remaining 6 buffered, NAK until timeout enabled.
- After first packet, withhold ACK, issue second token → identical bytes retransmitted with the same data_pid_o. ACK then flips toggle exactly once.
- USBUART_IN_ZLP_EN defined: send full 64-byte packet, ACK, FIFO empty, timeout_i=4, token after 4 cycles → ZLP with in_empty_o=1, data_pid_o=1. Macro undefined → NAK.
- in_ready_i held low 5 cycles mid-packet → in_data_o/in_valid_o stable, no byte lost or duplicated.
- clear_i asserted in SEND, and rst_ni dropped mid-WAIT_ACK → state FILL, pkt_len_o=0, data_pid_o=0, in_valid_o=0 next cycle / immediately.
